// File: rtl/rs232_receiver.sv
// rs232_receiver: 8N1-style deframer, mid-bit sampling, valid/framing-error strobes.
// Ports: clk, rst_n, rx (serial in); data_out, data_valid, frame_err, busy, idle.
module rs232_receiver #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic                 idle
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] C_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic                 r_rx_meta;
  logic                 r_rx_sync;
  logic [1:0]           r_sync_ok;
  logic                 r_armed;
  logic [2:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_valid;
  logic                 r_err;
  logic [DATA_BITS-1:0] w_shift_nxt;

  // LSB arrives first, so new bits enter at the top and walk down.
  generate
    if (DATA_BITS == 1) begin : g_one
      assign w_shift_nxt = r_rx_sync;
    end else begin : g_many
      assign w_shift_nxt = {r_rx_sync, r_shift[DATA_BITS-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_sync_ok  <= 2'b00;
      r_armed    <= 1'b0;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_sync_ok <= {r_sync_ok[0], 1'b1};
      // After reset the line must be seen high through the
      // synchroniser before a low is trusted as a start bit;
      // this keeps the tail of an aborted frame from deframing.
      if (r_sync_ok[1] && r_rx_sync)
        r_armed <= 1'b1;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_armed && !r_rx_sync) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_cnt == C_HALF) begin
            if (!r_rx_sync) begin
              r_state   <= S_DATA;
              r_cnt     <= '0;
              r_bit_idx <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == C_LAST) begin
            r_shift   <= w_shift_nxt;
            r_cnt     <= '0;
            r_bit_idx <= r_bit_idx + BW'(1);
            if (r_bit_idx == B_LAST)
              r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (r_cnt == C_LAST) begin
            r_cnt <= '0;
            if (r_rx_sync) begin
              r_data_out <= r_shift;
              r_valid    <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // Hold off start detection while a break keeps the line low.
        S_BREAK: begin
          if (r_rx_sync)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_valid;
  assign frame_err  = r_err;
  assign busy       = (r_state != S_IDLE);
  assign idle       = (r_state == S_IDLE);

endmodule

// File: tb/tb_rs232_receiver.sv
// tb_rs232_receiver: directed vector bench for rs232_receiver.
// Default instance (16 clk/bit) plus a 2 clk/bit instance.
module tb_rs232_receiver;

  localparam int LAT_A = 8 + 9 * 16 + 3;
  localparam int LAT_B = 1 + 9 * 2 + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a;
  logic       rx_b;
  logic [7:0] do_a, do_b;
  logic       dv_a, dv_b;
  logic       fe_a, fe_b;
  logic       busy_a, busy_b;
  logic       idle_a, idle_b;

  rs232_receiver u_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a),
    .data_out(do_a), .data_valid(dv_a), .frame_err(fe_a),
    .busy(busy_a), .idle(idle_a)
  );

  rs232_receiver #(.DATA_BITS(8), .CLKS_PER_BIT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b),
    .data_out(do_b), .data_valid(dv_b), .frame_err(fe_b),
    .busy(busy_b), .idle(idle_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         va_cyc[$];
  logic [7:0] va_dat[$];
  int         ea_cyc[$];
  int         ba_rise[$];
  int         vb_cyc[$];
  logic [7:0] vb_dat[$];
  int         both = 0;
  int         idlebad = 0;
  logic       busy_q = 1'b0;

  always @(negedge clk) begin
    if (dv_a) begin
      va_cyc.push_back(cyc);
      va_dat.push_back(do_a);
    end
    if (fe_a) ea_cyc.push_back(cyc);
    if (busy_a && !busy_q) ba_rise.push_back(cyc);
    busy_q = busy_a;
    if (dv_b) begin
      vb_cyc.push_back(cyc);
      vb_dat.push_back(do_b);
    end
    if (dv_a && fe_a) both++;
    if (dv_b && fe_b) both++;
    if (idle_a == busy_a) idlebad++;
    if (idle_b == busy_b) idlebad++;
  end

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    va_cyc.delete();
    va_dat.delete();
    ea_cyc.delete();
    ba_rise.delete();
    vb_cyc.delete();
    vb_dat.delete();
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [7:0] qb(input logic [7:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 8'hxx;
  endfunction

  task automatic put(input bit sel, input logic lvl, input int n);
    if (sel) rx_b = lvl;
    else rx_a = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input logic [7:0] d,
                      input logic stop, input int cpb, output int st);
    st = cyc;
    put(sel, 1'b0, cpb);
    for (int i = 0; i < 8; i++) put(sel, d[i], cpb);
    put(sel, stop, cpb);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_dout"}, do_a, 8'h00);
    chk({nm, "_valid"}, dv_a, 1'b0);
    chk({nm, "_err"}, fe_a, 1'b0);
    chk({nm, "_busy"}, busy_a, 1'b0);
    chk({nm, "_idle"}, idle_a, 1'b1);
  endtask

  typedef struct {
    logic [7:0] d;
    int         gap;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t tab[5];
  int   st[5];
  int   s;
  int   s_rst;

  initial begin
    tab[0] = '{8'hAB, 40, 8'hAB};
    tab[1] = '{8'h00,  0, 8'h00};
    tab[2] = '{8'hFF,  0, 8'hFF};
    tab[3] = '{8'h55, 40, 8'h55};
    tab[4] = '{8'h81, 40, 8'h81};

    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("rst");
    chk("rst_dout_b", do_b, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    put(0, 1'b1, 10);

    // Table: single frame, then back-to-back 00/FF/55, then one more.
    clr();
    for (int i = 0; i < 5; i++) begin
      send(0, tab[i].d, 1'b1, 16, s);
      st[i] = s;
      put(0, 1'b1, tab[i].gap);
    end
    put(0, 1'b1, 40);
    chk("tab_nvalid", va_cyc.size(), 5);
    chk("tab_nerr", ea_cyc.size(), 0);
    chk("tab_busy_rise", qi(ba_rise, 0) - st[0], 3);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("tab%0d_lat", i), qi(va_cyc, i) - st[i], LAT_A);
      chk($sformatf("tab%0d_data", i), qb(va_dat, i), tab[i].exp_dout);
    end
    chk("tab_b2b_space", qi(va_cyc, 2) - qi(va_cyc, 1), 160);
    chk("tab_busy_end", busy_a, 1'b0);

    // Glitch: 3-cycle low pulse is a false start.
    clr();
    put(0, 1'b0, 3);
    put(0, 1'b1, 40);
    chk("gl_nvalid", va_cyc.size(), 0);
    chk("gl_nerr", ea_cyc.size(), 0);
    chk("gl_busy_pulse", ba_rise.size(), 1);
    chk("gl_idle", idle_a, 1'b1);
    send(0, 8'h3C, 1'b1, 16, s);
    put(0, 1'b1, 40);
    chk("gl_3c_n", va_cyc.size(), 1);
    chk("gl_3c_lat", qi(va_cyc, 0) - s, LAT_A);
    chk("gl_3c_data", qb(va_dat, 0), 8'h3C);

    // Framing error followed by a long break.
    clr();
    send(0, 8'hA5, 1'b0, 16, s);
    put(0, 1'b0, 50 * 16);
    chk("fe_n", ea_cyc.size(), 1);
    chk("fe_lat", qi(ea_cyc, 0) - s, LAT_A);
    chk("fe_nvalid", va_cyc.size(), 0);
    chk("fe_dout_hold", do_a, 8'h3C);
    chk("fe_break_busy", busy_a, 1'b1);
    chk("fe_busy_rises", ba_rise.size(), 1);
    put(0, 1'b1, 20);
    chk("fe_release_idle", busy_a, 1'b0);
    send(0, 8'h12, 1'b1, 16, s);
    put(0, 1'b1, 40);
    chk("fe_12_n", va_cyc.size(), 1);
    chk("fe_12_lat", qi(va_cyc, 0) - s, LAT_A);
    chk("fe_12_data", qb(va_dat, 0), 8'h12);
    chk("fe_12_nerr", ea_cyc.size(), 1);

    // Reset asserted during bit 4 of 0xC3.
    clr();
    fork
      begin
        send(0, 8'hC3, 1'b1, 16, s_rst);
        put(0, 1'b1, 40);
      end
      begin
        repeat (70) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outs("mid_rst");
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    join
    chk("rst_nvalid", va_cyc.size(), 0);
    chk("rst_nerr", ea_cyc.size(), 0);
    send(0, 8'h96, 1'b1, 16, s);
    put(0, 1'b1, 40);
    chk("rst_96_n", va_cyc.size(), 1);
    chk("rst_96_lat", qi(va_cyc, 0) - s, LAT_A);
    chk("rst_96_data", qb(va_dat, 0), 8'h96);

    // Two clocks per bit.
    clr();
    send(1, 8'hAB, 1'b1, 2, s);
    put(1, 1'b1, 20);
    chk("b_n", vb_cyc.size(), 1);
    chk("b_lat", qi(vb_cyc, 0) - s, LAT_B);
    chk("b_data", qb(vb_dat, 0), 8'hAB);

    chk("both_strobes", both, 0);
    chk("idle_vs_busy", idlebad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
